// File: rtl/rst_sequencer.sv
// Staged reset release for NDOMAINS active-low domains behind PRCI, plus a
// valid/ready software-reset path that pulses and re-sequences selected domains.
module rst_sequencer #(
  parameter int NDOMAINS    = 4,
  parameter int STAGE_DELAY = 16,
  parameter int PULSE_WIDTH = 8,
  parameter int CNT_W       = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  input  logic [NDOMAINS-1:0] i_req_mask,
  output logic                o_req_ready,
  output logic                o_resp_valid,
  output logic [NDOMAINS-1:0] o_nrst,
  output logic                o_busy
);

  localparam int IDX_W   = $clog2(NDOMAINS + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDOMAINS - 1);

  // Counter compare is equality, so a too-narrow counter would wrap forever.
  if (STAGE_DELAY > CNT_MAX || PULSE_WIDTH > CNT_MAX) begin : g_cnt_w_chk
    $error("rst_sequencer: CNT_W too narrow for STAGE_DELAY/PULSE_WIDTH");
  end

  typedef enum logic [2:0] {
    S_RESET, S_RELEASE, S_RUN, S_PULSE, S_RESEQ, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [NDOMAINS-1:0] mask, mask_nxt, nrst_nxt;
  logic                ready_nxt, resp_nxt, busy_nxt;

  // Next selected domain at or above idx; unselected indices cost no cycles.
  logic             found, more;
  logic [IDX_W-1:0] cur;
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    cur   = '0;
    for (int k = 0; k < NDOMAINS; k++) begin
      if (mask[k] && (IDX_W'(k) >= idx)) begin
        if (!found) begin
          found = 1'b1;
          cur   = IDX_W'(k);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    mask_nxt  = mask;
    nrst_nxt  = o_nrst;
    resp_nxt  = 1'b0;
    case (state)
      S_RESET: begin
        state_nxt = S_RELEASE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
      S_RELEASE: begin
        if (cnt == SD_LAST) begin
          for (int k = 0; k < NDOMAINS; k++)
            if (IDX_W'(k) == idx) nrst_nxt[k] = 1'b1;
          cnt_nxt = '0;
          idx_nxt = idx + 1'b1;
          if (idx == IDX_LAST) state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (i_req_valid && o_req_ready) begin
          mask_nxt = i_req_mask;
          cnt_nxt  = '0;
          if (|i_req_mask) begin
            nrst_nxt  = o_nrst & ~i_req_mask;
            state_nxt = S_PULSE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_PULSE: begin
        if (cnt == PW_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_RESEQ;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RESEQ: begin
        if (!found) begin
          state_nxt = S_DONE;
        end else if (cnt == SD_LAST) begin
          for (int k = 0; k < NDOMAINS; k++)
            if (IDX_W'(k) == cur) nrst_nxt[k] = 1'b1;
          cnt_nxt = '0;
          idx_nxt = cur + 1'b1;
          if (!more) state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        resp_nxt  = 1'b1;
        state_nxt = S_RUN;
      end
      default: state_nxt = S_RESET;
    endcase
    ready_nxt = (state_nxt == S_RUN);
    busy_nxt  = !ready_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_RESET;
      cnt          <= '0;
      idx          <= '0;
      mask         <= '0;
      o_nrst       <= '0;
      o_req_ready  <= 1'b0;
      o_resp_valid <= 1'b0;
      o_busy       <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      mask         <= mask_nxt;
      o_nrst       <= nrst_nxt;
      o_req_ready  <= ready_nxt;
      o_resp_valid <= resp_nxt;
      o_busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: timing-formula model checked every cycle on the default
// instance, plus literal expectations on it and on a 1-domain/1-cycle corner instance.
module tb_rst_sequencer;
  localparam int N  = 4;
  localparam int SD = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [N-1:0] req_mask = '0;
  logic         req_ready, resp_valid, busy;
  logic [N-1:0] nrst;

  logic       c_valid = 1'b0;
  logic [0:0] c_mask = 1'b0;
  logic       c_ready, c_resp, c_busy;
  logic [0:0] c_nrst;

  rst_sequencer #(.NDOMAINS(N), .STAGE_DELAY(SD), .PULSE_WIDTH(PW), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_mask(req_mask),
    .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_nrst(nrst), .o_busy(busy)
  );

  rst_sequencer #(.NDOMAINS(1), .STAGE_DELAY(1), .PULSE_WIDTH(1), .CNT_W(8)) u_corner (
    .i_clk(clk), .i_rst(rst), .i_req_valid(c_valid), .i_req_mask(c_mask),
    .o_req_ready(c_ready), .o_resp_valid(c_resp), .o_nrst(c_nrst), .o_busy(c_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: edge numbers of power-up start and of the accepted request; every
  // output is a pure function of the current edge number and those timestamps.
  int           cyc = 0;
  int           pwr_edge = -1;
  int           resp_edge = 0;
  bit           in_rst = 1'b1;
  bit           have_req = 1'b0;
  logic [N-1:0] rq_mask = '0;
  int           rise [N];

  function automatic bit e_ready(input int t);
    if (pwr_edge < 0) return 1'b0;
    if (t < pwr_edge + N * SD) return 1'b0;
    return !have_req || (t >= resp_edge);
  endfunction

  function automatic logic [N-1:0] e_nrst(input int t);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++)
      r[k] = (pwr_edge >= 0) && (t >= pwr_edge + (k + 1) * SD) &&
             !(have_req && rq_mask[k] && (t < rise[k]));
    return r;
  endfunction

  function automatic bit e_resp(input int t);
    return have_req && (t == resp_edge);
  endfunction

  always @(posedge clk) begin
    bit rdy;
    int rank;
    rdy = e_ready(cyc);
    cyc++;
    if (rst) begin
      pwr_edge = -1;
      in_rst   = 1'b1;
      have_req = 1'b0;
    end else if (in_rst) begin
      in_rst   = 1'b0;
      pwr_edge = cyc;
    end else if (req_valid && rdy) begin
      have_req = 1'b1;
      rq_mask  = req_mask;
      rank     = 0;
      for (int k = 0; k < N; k++) begin
        rise[k] = 0;
        if (req_mask[k]) begin
          rank++;
          rise[k] = cyc + PW + rank * SD;
        end
      end
      resp_edge = (rank == 0) ? cyc + 1 : cyc + PW + rank * SD + 1;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_nrst",  nrst,       e_nrst(cyc));
      chk("model_ready", req_ready,  e_ready(cyc));
      chk("model_busy",  busy,       !e_ready(cyc));
      chk("model_resp",  resp_valid, e_resp(cyc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset held for three edges
    step(1);
    chk_en = 1'b1;
    chk("rst_nrst", nrst, 4'b0000);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_resp", resp_valid, 1'b0);
    step(2);
    rst = 1'b0;

    // power-up; corner instance exercised in the first few cycles
    step(1);                                   // after E0
    chk("pwr_nrst_e0", nrst, 4'b0000);
    chk("c_nrst_e0", c_nrst, 1'b0);
    step(1);                                   // after E0+1
    chk("c_nrst_e1", c_nrst, 1'b1);
    chk("c_ready_e1", c_ready, 1'b1);
    c_valid = 1'b1;
    c_mask  = 1'b1;
    step(1);                                   // after H=E0+2
    c_valid = 1'b0;
    chk("c_nrst_h", c_nrst, 1'b0);
    chk("c_ready_h", c_ready, 1'b0);
    step(1);
    chk("c_nrst_h1", c_nrst, 1'b0);
    step(1);
    chk("c_nrst_h2", c_nrst, 1'b1);
    chk("c_resp_h2", c_resp, 1'b0);
    step(1);
    chk("c_resp_h3", c_resp, 1'b1);
    chk("c_ready_h3", c_ready, 1'b1);
    step(1);
    chk("c_resp_h4", c_resp, 1'b0);
    step(9);                                   // after E0+15
    chk("pwr_nrst_e15", nrst, 4'b0000);
    step(1);
    chk("pwr_nrst_e16", nrst, 4'b0001);
    step(15);
    chk("pwr_nrst_e31", nrst, 4'b0001);
    step(1);
    chk("pwr_nrst_e32", nrst, 4'b0011);
    step(16);
    chk("pwr_nrst_e48", nrst, 4'b0111);
    step(15);
    chk("pwr_nrst_e63", nrst, 4'b0111);
    chk("pwr_ready_e63", req_ready, 1'b0);
    chk("pwr_busy_e63", busy, 1'b1);
    step(1);
    chk("pwr_nrst_e64", nrst, 4'b1111);
    chk("pwr_ready_e64", req_ready, 1'b1);
    chk("pwr_busy_e64", busy, 1'b0);

    // software reset of domains 0 and 2
    req_valid = 1'b1;
    req_mask  = 4'b0101;
    step(1);                                   // after H
    req_valid = 1'b0;
    chk("sw_nrst_h", nrst, 4'b1010);
    chk("sw_ready_h", req_ready, 1'b0);
    step(7);
    chk("sw_nrst_h7", nrst, 4'b1010);
    step(16);
    chk("sw_nrst_h23", nrst, 4'b1010);
    step(1);
    chk("sw_nrst_h24", nrst, 4'b1011);
    step(15);
    chk("sw_nrst_h39", nrst, 4'b1011);
    step(1);
    chk("sw_nrst_h40", nrst, 4'b1111);
    chk("sw_resp_h40", resp_valid, 1'b0);
    step(1);
    chk("sw_resp_h41", resp_valid, 1'b1);
    step(1);
    chk("sw_resp_h42", resp_valid, 1'b0);

    // empty mask
    req_valid = 1'b1;
    req_mask  = 4'b0000;
    step(1);
    req_valid = 1'b0;
    chk("m0_resp_h", resp_valid, 1'b0);
    chk("m0_ready_h", req_ready, 1'b0);
    step(1);
    chk("m0_resp_h1", resp_valid, 1'b1);
    chk("m0_nrst_h1", nrst, 4'b1111);
    step(1);
    chk("m0_resp_h2", resp_valid, 1'b0);

    // reset pulse during RESEQ aborts the request
    req_valid = 1'b1;
    req_mask  = 4'b0011;
    step(1);
    req_valid = 1'b0;
    chk("ab_nrst_h", nrst, 4'b1100);
    step(13);
    rst = 1'b1;
    step(1);
    chk("ab_nrst_r", nrst, 4'b0000);
    chk("ab_busy_r", busy, 1'b1);
    rst       = 1'b0;
    req_valid = 1'b1;                          // held through RELEASE
    req_mask  = 4'b1000;
    step(1);                                   // after E0'
    chk("ab_nrst_e0", nrst, 4'b0000);
    step(62);
    req_mask = 4'b0010;
    step(1);
    chk("hold_ready_e63", req_ready, 1'b0);
    step(1);
    chk("hold_ready_e64", req_ready, 1'b1);
    step(1);                                   // after handshake H
    chk("hold_nrst_h", nrst, 4'b1101);
    req_mask = 4'b1000;                        // still valid, ignored until RUN
    step(24);
    chk("hold_nrst_h24", nrst, 4'b1111);
    step(1);
    chk("hold_resp_h25", resp_valid, 1'b1);
    step(1);
    chk("hold_nrst_h26", nrst, 4'b0111);
    req_valid = 1'b0;
    step(30);
    chk("hold_nrst_end", nrst, 4'b1111);
    chk("hold_ready_end", req_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
